// File: rtl/instruction_fetch_stage_pkg.sv
// Shared fetch-stage types: machine word, word address, and the FIFO entry
// that pairs a fetched instruction with the byte address it came from.
package instruction_fetch_stage_pkg;

  typedef logic [31:0] word;
  typedef logic [31:0] word_address;

  localparam int unsigned INSTRUCTION_BYTES = 4;

  typedef struct packed {
    word_address pc;
    word         instruction;
  } fetch_entry;

  function automatic word_address align_word(input word_address a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_fetch_fifo.sv
// Synchronous FIFO of fetch entries with a single-cycle flush; flush beats a
// concurrent push or pop.
module fetch_fifo
  import instruction_fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry             push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry             head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry    mem_q [DEPTH];
  fetch_entry    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, issues one-cycle-latency word reads, and buffers
// returned instructions for decode. Redirects flush the buffer and the read.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter word_address RESET_PC = '0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        jump,
  input  logic [31:0] jump_location,
  output logic [31:0] fetch_address,
  output logic        fetch_enable,
  input  logic [31:0] content,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  word_address   pc_q, pc_d;
  word_address   issue_pc_q, issue_pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count;
  fetch_entry    head, push_data;
  logic          push, pop;

  always_comb begin
    // An in-flight read holds a credit so its data always has a slot.
    fetch_enable = !reset && !jump && ((count + CW'(inflight_q)) < CW'(DEPTH));
    pc_d         = pc_q;
    if (jump)              pc_d = align_word(jump_location);
    else if (fetch_enable) pc_d = pc_q + 32'(INSTRUCTION_BYTES);
    issue_pc_d   = fetch_enable ? pc_q : issue_pc_q;
    inflight_d   = fetch_enable;
    push         = inflight_q;
    push_data    = '{pc: issue_pc_q, instruction: content};
    out_valid    = !reset && (count != '0);
    pop          = out_valid && out_ready;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      issue_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      issue_pc_q <= issue_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (jump),
    .count     (count),
    .head      (head)
  );

  assign fetch_address   = pc_q;
  assign out_instruction = head.instruction;
  assign out_pc          = head.pc;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: memory model, directed scenarios, random
// traffic, and a scoreboard of the expected decode-side instruction stream.
module tb_instruction_fetch_stage;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] IMG_KEY  = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        reset, jump, out_ready;
  logic [31:0] jump_location;
  logic [31:0] fetch_address, content, out_instruction, out_pc;
  logic        fetch_enable, out_valid;
  logic [31:0] rd_addr = 32'h0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pops   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] gen_pc = 32'h0;

  always #5 clock = ~clock;

  instruction_fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock           (clock),
    .reset           (reset),
    .jump            (jump),
    .jump_location   (jump_location),
    .fetch_address   (fetch_address),
    .fetch_enable    (fetch_enable),
    .content         (content),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc)
  );

  // Instruction memory: word at byte address A is A ^ IMG_KEY, one-cycle latency.
  always @(posedge clock) if (fetch_enable) rd_addr <= fetch_address;
  assign content = rd_addr ^ IMG_KEY;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Monitor + reference model: decode must see consecutive word addresses
  // starting at the most recent redirect (reset -> RESET_PC, jump -> target).
  initial forever begin
    logic [31:0] exp;
    @(negedge clock);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_pops++;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : ~out_pc;
      check32("pop_pc", out_pc, exp);
      check32("pop_instr", out_instruction, exp ^ IMG_KEY);
    end
    if (reset === 1'b1 || jump === 1'b1) check1("no_issue_on_redirect", fetch_enable, 1'b0);
    if (reset === 1'b1) begin
      exp_q.delete();
      gen_pc = RESET_PC;
    end else if (jump === 1'b1) begin
      exp_q.delete();
      gen_pc = jump_location & 32'hFFFF_FFFC;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  end

  initial begin
    reset = 1'b1; jump = 1'b0; out_ready = 1'b1; jump_location = 32'h0;

    // 1: reset state, first-valid latency, back-to-back stream
    cyc();
    @(negedge clock);
    check1("rst_fetch_enable", fetch_enable, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_fetch_address", fetch_address, RESET_PC);
    cyc(); reset = 1'b0;
    @(negedge clock); check1("lat_cycle0_valid", out_valid, 1'b0);
    cyc(); @(negedge clock); check1("lat_cycle1_valid", out_valid, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(); @(negedge clock); check1("stream_valid", out_valid, 1'b1);
    end

    // 2: decode stalls, buffer fills, fetch holds at 0x10
    cyc(); reset = 1'b1; out_ready = 1'b0;
    cyc();
    cyc(); reset = 1'b0;
    repeat (9) cyc();
    @(negedge clock);
    check1("full_fetch_enable", fetch_enable, 1'b0);
    check32("full_fetch_address", fetch_address, 32'h10);
    check1("full_out_valid", out_valid, 1'b1);
    check32("full_head_pc", out_pc, 32'h0);
    cyc(); out_ready = 1'b1;
    repeat (14) cyc();

    // 3: jump at cycle 6 after reset
    cyc(); reset = 1'b1;
    cyc();
    cyc(); reset = 1'b0;
    repeat (6) cyc();
    jump = 1'b1; jump_location = 32'h40;
    @(negedge clock); check1("jump_cycle_issue", fetch_enable, 1'b0);
    cyc(); jump = 1'b0;
    @(negedge clock);
    check32("jump_next_fetch_address", fetch_address, 32'h40);
    check1("jump_next_fetch_enable", fetch_enable, 1'b1);
    check1("jump_j1_valid", out_valid, 1'b0);
    cyc(); @(negedge clock); check1("jump_j2_valid", out_valid, 1'b0);
    cyc(); @(negedge clock);
    check1("jump_j3_valid", out_valid, 1'b1);
    check32("jump_j3_pc", out_pc, 32'h40);
    repeat (6) cyc();

    // 4: jump while full and stalled
    out_ready = 1'b0;
    repeat (8) cyc();
    @(negedge clock); check1("full2_out_valid", out_valid, 1'b1);
    cyc(); jump = 1'b1; jump_location = 32'h100;
    cyc(); jump = 1'b0;
    @(negedge clock);
    check1("flush_out_valid", out_valid, 1'b0);
    check32("flush_fetch_address", fetch_address, 32'h100);
    cyc(); out_ready = 1'b1;
    cyc(); @(negedge clock);
    check1("refill_valid", out_valid, 1'b1);
    check32("refill_pc", out_pc, 32'h100);
    repeat (8) cyc();

    // 5: reset mid-run with 3 buffered entries and a read in flight
    out_ready = 1'b0; reset = 1'b1;
    cyc();
    cyc(); reset = 1'b0;
    repeat (3) cyc();
    @(negedge clock);
    check1("pre_reset_valid", out_valid, 1'b1);
    check32("pre_reset_pc", out_pc, 32'h0);
    cyc(); reset = 1'b1;
    @(negedge clock); check1("reset_pulse_valid", out_valid, 1'b0);
    cyc(); reset = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    check1("post_reset_valid", out_valid, 1'b0);
    check32("post_reset_fetch_address", fetch_address, RESET_PC);
    cyc(); @(negedge clock); check1("post_reset_valid_c1", out_valid, 1'b0);
    cyc(); @(negedge clock);
    check1("post_reset_valid_c2", out_valid, 1'b1);
    check32("post_reset_pc", out_pc, RESET_PC);
    repeat (4) cyc();

    // 6: back-to-back jumps, last one wins; unaligned target
    jump = 1'b1; jump_location = 32'h80;
    cyc(); jump_location = 32'hC0;
    cyc(); jump = 1'b0;
    @(negedge clock);
    check32("b2b_fetch_address", fetch_address, 32'hC0);
    check1("b2b_j1_valid", out_valid, 1'b0);
    cyc(); @(negedge clock); check1("b2b_j2_valid", out_valid, 1'b0);
    cyc(); @(negedge clock);
    check1("b2b_j3_valid", out_valid, 1'b1);
    check32("b2b_first_pc", out_pc, 32'hC0);
    repeat (4) cyc();
    jump = 1'b1; jump_location = 32'h83;
    cyc(); jump = 1'b0;
    @(negedge clock); check32("unaligned_target", fetch_address, 32'h80);
    repeat (5) cyc();

    // Random traffic, including targets near the top of the address space
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset     = ($urandom_range(99) < 1);
      jump      = ($urandom_range(99) < 6);
      out_ready = ($urandom_range(99) < 70);
      if ($urandom_range(3) == 0) jump_location = 32'hFFFF_FFE0 | 32'($urandom_range(31));
      else                        jump_location = $urandom;
    end
    cyc(); reset = 1'b0; jump = 1'b0; out_ready = 1'b1;
    repeat (6) cyc();
    check1("throughput", n_pops > 1000, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
